motor_pwm_driver: RTL and testbench

Downstream consumer of the instruction word popped from the instruction FIFO (torque[4:2], direction[1:0]).
- Converts the active instruction into left/right motor PWM and direction pins, gated by the FSM's timer-enable.
- Ramps duty at a bounded slew so torque steps are soft.
- A direction flip on either wheel forces ramp-down, then a dead time, before the new direction is applied.
- Runs alongside the torque/direction displays, which show the same word.

---
 rtl/robot_pkg.sv | 40 ++++
 rtl/motor_pwm_driver_pwm_gen.sv | 39 +++
 rtl/motor_pwm_driver.sv | 150 +++++++++++++++
 tb/tb_motor_pwm_driver.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/robot_pkg.sv
// Shared types for the robot drive path: instruction word,
// wheel direction encoding, driver FSM states and duty lookup.
package robot_pkg;

  typedef enum logic [1:0] {
    DIR_FWD   = 2'b00,
    DIR_REV   = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef struct packed {
    logic [2:0] torque;
    dir_e       dir;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    RUN,
    DEAD
  } drv_state_e;

  function automatic int duty_table(input int k, input int period);
    return (k * period) / 7;
  endfunction

  // Returns {left, right}, 1 = forward
  function automatic logic [1:0] dir_decode(input dir_e d);
    logic [1:0] lr;
    unique case (d)
      DIR_FWD:  lr = 2'b11;
      DIR_REV:  lr = 2'b00;
      DIR_LEFT: lr = 2'b01;
      default:  lr = 2'b10;
    endcase
    return lr;
  endfunction

endpackage

// File: rtl/motor_pwm_driver_pwm_gen.sv
// Frame counter with a compare shadow that only reloads on the
// last count of a frame, so duty changes never split a frame.
module pwm_gen #(
  parameter int PERIOD = 1000,
  parameter int DW     = $clog2(PERIOD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] duty_i,
  output logic          pwm_o
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] cmp_q, cmp_d;
  logic          wrap;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    cmp_d = wrap ? duty_i : cmp_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      cmp_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cmp_q <= cmp_d;
    end
  end

  assign pwm_o = (DW'(cnt_q) < cmp_q);

endmodule

// File: rtl/motor_pwm_driver.sv
// Two-wheel PWM driver: slew-limited duty ramp, with a forced
// ramp-down and dead time around every direction change.
module motor_pwm_driver
  import robot_pkg::*;
#(
  parameter int PWM_PERIOD  = 1000,
  parameter int RAMP_TICK   = 50000,
  parameter int DUTY_STEP   = 10,
  parameter int DEAD_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [4:0] instruction,
  output logic       pwm_left,
  output logic       pwm_right,
  output logic       dir_left,
  output logic       dir_right,
  output logic       moving,
  output logic       at_speed
);

  localparam int DW = $clog2(PWM_PERIOD + 1);
  localparam int RW = $clog2(RAMP_TICK + 1);
  localparam int XW = $clog2(DEAD_CYCLES + 1);
  localparam logic [DW-1:0] STEP = DW'(DUTY_STEP);

  instr_t        ins;
  drv_state_e    state_q, state_d;
  logic [DW-1:0] tgt_duty_q, tgt_duty_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] eff, diff, mag;
  logic [1:0]    tgt_dir_q, tgt_dir_d;
  logic [1:0]    dir_q, dir_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic [XW-1:0] dead_q, dead_d;
  logic          tick, dead_done, dir_match;
  logic          ramp_run, slew_en, dead_act;
  logic          pwm_raw, pwm_q, moving_q, at_speed_q;

  assign ins       = instr_t'(instruction);
  assign dir_match = (tgt_dir_q == dir_q);
  assign eff       = dir_match ? tgt_duty_q : '0;
  assign tick      = (ramp_q == RW'(RAMP_TICK - 1));
  assign dead_done = (dead_q == XW'(DEAD_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!dir_match)      state_d = DEAD;
        else if (eff != '0)  state_d = RAMP;
      end
      RAMP: begin
        if (duty_q == '0 && !dir_match) state_d = DEAD;
        else if (duty_q == eff)
          state_d = (eff == '0) ? IDLE : RUN;
      end
      RUN: begin
        if (duty_q != eff) state_d = RAMP;
      end
      DEAD: begin
        if (dead_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramp_run = 1'b1;
    slew_en  = 1'b0;
    dead_act = 1'b0;
    unique case (state_q)
      IDLE:    ramp_run = 1'b0;
      RAMP:    slew_en  = 1'b1;
      DEAD:    dead_act = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    tgt_duty_d = enable
      ? DW'(duty_table(int'(ins.torque), PWM_PERIOD))
      : '0;
    tgt_dir_d = enable ? dir_decode(ins.dir) : tgt_dir_q;
    ramp_d = (!ramp_run || tick) ? '0 : ramp_q + RW'(1);
    dead_d = dead_act ? dead_q + XW'(1) : '0;
    dir_d  = (dead_act && dead_done) ? tgt_dir_q : dir_q;
    diff   = (duty_q > eff) ? duty_q - eff : eff - duty_q;
    mag    = (diff < STEP) ? diff : STEP;
    duty_d = duty_q;
    if (!ramp_run) begin
      duty_d = '0;
    end else if (slew_en && tick) begin
      unique case (1'b1)
        (duty_q < eff): duty_d = duty_q + mag;
        (duty_q > eff): duty_d = duty_q - mag;
        default:        duty_d = duty_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgt_duty_q <= '0;
      tgt_dir_q  <= 2'b11;
      duty_q     <= '0;
      dir_q      <= 2'b11;
      ramp_q     <= '0;
      dead_q     <= '0;
      pwm_q      <= 1'b0;
      moving_q   <= 1'b0;
      at_speed_q <= 1'b0;
    end else begin
      tgt_duty_q <= tgt_duty_d;
      tgt_dir_q  <= tgt_dir_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      ramp_q     <= ramp_d;
      dead_q     <= dead_d;
      pwm_q      <= pwm_raw && !dead_act;
      moving_q   <= (duty_q != '0);
      at_speed_q <= (state_q == RUN) && dir_match
                    && (duty_q == eff);
    end
  end

  pwm_gen #(
    .PERIOD (PWM_PERIOD),
    .DW     (DW)
  ) u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .duty_i (duty_q),
    .pwm_o  (pwm_raw)
  );

  assign pwm_left  = pwm_q;
  assign pwm_right = pwm_q;
  assign dir_left  = dir_q[1];
  assign dir_right = dir_q[0];
  assign moving    = moving_q;
  assign at_speed  = at_speed_q;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Scenario bench for motor_pwm_driver with small timing parameters;
// expectations are queued per scenario and popped as outputs are sampled.
module tb_motor_pwm_driver;
  import robot_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [4:0] instruction = '0;
  logic       pwm_left, pwm_right, dir_left, dir_right;
  logic       moving, at_speed;

  int    checks = 0;
  int    errors = 0;
  string tag_q[$];
  int    exp_q[$];

  always #5 clk = ~clk;

  motor_pwm_driver #(
    .PWM_PERIOD  (16),
    .RAMP_TICK   (4),
    .DUTY_STEP   (1),
    .DEAD_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .instruction (instruction),
    .pwm_left    (pwm_left),
    .pwm_right   (pwm_right),
    .dir_left    (dir_left),
    .dir_right   (dir_right),
    .moving      (moving),
    .at_speed    (at_speed)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop(input int obs);
    if (exp_q.size() == 0) begin
      check("sb_empty", obs, obs + 1);
      return;
    end
    check(tag_q.pop_front(), obs, exp_q.pop_front());
  endtask

  task automatic exp_out(input string p, input int pl, input int pr,
                         input int dl, input int dr,
                         input int mv, input int as);
    push({p, "_pwm_l"}, pl);
    push({p, "_pwm_r"}, pr);
    push({p, "_dir_l"}, dl);
    push({p, "_dir_r"}, dr);
    push({p, "_moving"}, mv);
    push({p, "_at_speed"}, as);
  endtask

  task automatic obs_out();
    pop(int'(pwm_left));
    pop(int'(pwm_right));
    pop(int'(dir_left));
    pop(int'(dir_right));
    pop(int'(moving));
    pop(int'(at_speed));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // High cycles of each PWM over one full 16-cycle frame
  task automatic hi_count(output int hl, output int hr);
    hl = 0;
    hr = 0;
    repeat (16) begin
      @(negedge clk);
      hl += int'(pwm_left);
      hr += int'(pwm_right);
    end
  endtask

  function automatic bit cond(input int sel, input int v);
    case (sel)
      0:       return at_speed;
      1:       return !moving;
      2:       return dir_right;
      4:       return moving;
      default: return int'(dut.duty_q) == v;
    endcase
  endfunction

  task automatic wait_cond(input int sel, input int v,
                           input int budget, output int n);
    n = 0;
    while (!cond(sel, v) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!cond(sel, v)) n = -1;
  endtask

  task automatic steady(input string p, input int duty,
                        input int dl, input int dr);
    int hl, hr;
    push({p, "_hi_l"}, duty);
    push({p, "_hi_r"}, duty);
    push({p, "_at_speed"}, 1);
    push({p, "_dir_l"}, dl);
    push({p, "_dir_r"}, dr);
    hi_count(hl, hr);
    pop(hl);
    pop(hr);
    pop(int'(at_speed));
    pop(int'(dir_left));
    pop(int'(dir_right));
  endtask

  initial begin
    int n, low, hi, chg;

    // 1: reset with arbitrary inputs
    @(negedge clk);
    rst_n = 1'b0;
    enable = 1'b1;
    instruction = 5'($urandom);
    exp_out("rst", 0, 0, 1, 1, 0, 0);
    cyc(3);
    obs_out();

    // 2: ramp to full torque forward
    instruction = 5'b11100;
    rst_n = 1'b1;
    push("t2_latency", 1);
    wait_cond(0, 0, 120, n);
    pop(int'(n >= 48 && n <= 84));
    cyc(24);
    steady("t2", 16, 1, 1);

    // 3: down to torque 3, then enable drop
    instruction = 5'b01100;
    cyc(80);
    steady("t3_run", 6, 1, 1);
    enable = 1'b0;
    push("t3_stop_time", 1);
    wait_cond(1, 0, 60, n);
    pop(int'(n >= 20 && n <= 30));
    cyc(4);
    push("t3_idle", int'(IDLE));
    pop(int'(dut.state_q));
    exp_out("t3_off", 0, 0, 1, 1, 0, 0);
    obs_out();

    // 4: forward torque 2, then reverse torque 2
    enable = 1'b1;
    instruction = 5'b01000;
    cyc(48);
    steady("t4_fwd", 4, 1, 1);
    instruction = 5'b01001;
    n = 0;
    low = 0;
    while (dir_left && n < 100) begin
      @(negedge clk);
      n++;
      low = (pwm_left || pwm_right) ? 0 : low + 1;
    end
    push("t4_flip_dl", 0);
    push("t4_flip_dr", 0);
    push("t4_dead_low", 1);
    push("t4_flip_moving", 0);
    pop(int'(dir_left));
    pop(int'(dir_right));
    pop(int'(low >= 8));
    pop(int'(moving));
    cyc(48);
    steady("t4_rev", 4, 0, 0);

    // 5: stop, then left spin from IDLE with retarget at duty 5
    enable = 1'b0;
    push("t5_stopped", 1);
    wait_cond(1, 0, 60, n);
    pop(int'(n >= 0));
    cyc(4);
    enable = 1'b1;
    instruction = 5'b11110;
    n = 0;
    hi = 0;
    while (!dir_right && n < 60) begin
      @(negedge clk);
      n++;
      hi += int'(pwm_left) + int'(pwm_right);
    end
    push("t5_dir_l", 0);
    push("t5_dir_r", 1);
    push("t5_no_pwm_dead", 0);
    pop(int'(dir_left));
    pop(int'(dir_right));
    pop(hi);
    push("t5_reach5", 1);
    wait_cond(5, 5, 60, n);
    pop(int'(n >= 0));
    instruction = 5'b00110;
    chg = 0;
    repeat (60) begin
      @(negedge clk);
      if (dir_left || !dir_right) chg++;
    end
    push("t5_dir_stable", 0);
    pop(chg);
    steady("t5_retarget", 2, 0, 1);

    // 6: reset in the middle of a ramp
    instruction = 5'b11110;
    push("t6_reach7", 1);
    wait_cond(5, 7, 60, n);
    pop(int'(n >= 0));
    rst_n = 1'b0;
    exp_out("t6_rst", 0, 0, 1, 1, 0, 0);
    push("t6_idle", int'(IDLE));
    @(negedge clk);
    obs_out();
    pop(int'(dut.state_q));
    instruction = 5'b11100;
    rst_n = 1'b1;
    push("t6_restart", 1);
    wait_cond(4, 0, 40, n);
    pop(int'(n >= 4 && n <= 9));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
